writeback_stage: RTL and testbench

- Final stage of the tiny 8-bit core, directly upstream of the register file write port.
- Accepts one retiring instruction at a time: either an ALU result or a load whose data must come from data memory.
- Performs the memory read handshake with a timeout, then drives a one-write commit into the 8x8 register file (R0 hard-wired to zero).
- Also exposes a forwarding tap and a commit counter.

---
 rtl/writeback_stage_if.sv | 38 +++
 rtl/writeback_stage.sv | 103 ++++++++++
 tb/tb_writeback_stage.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - retire, memory-read and register-file bundle for the writeback stage
interface writeback_stage_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_rd;
    logic       in_is_load;
    logic [7:0] in_alu_result;
    logic [7:0] in_mem_addr;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       mem_ready;
    logic       rf_ready;
    logic       rf_write_en;
    logic [2:0] rf_addr_wr;
    logic [7:0] rf_data_wr;
    logic       fwd_valid;
    logic [2:0] fwd_rd;
    logic [7:0] fwd_data;
    logic       err_timeout;
    logic [7:0] wb_count;

    modport master (
        input  in_valid, in_rd, in_is_load, in_alu_result, in_mem_addr,
        input  mem_rdata, mem_ready, rf_ready,
        output in_ready, mem_req, mem_addr,
        output rf_write_en, rf_addr_wr, rf_data_wr,
        output fwd_valid, fwd_rd, fwd_data, err_timeout, wb_count
    );

    modport slave (
        output in_valid, in_rd, in_is_load, in_alu_result, in_mem_addr,
        output mem_rdata, mem_ready, rf_ready,
        input  in_ready, mem_req, mem_addr,
        input  rf_write_en, rf_addr_wr, rf_data_wr,
        input  fwd_valid, fwd_rd, fwd_data, err_timeout, wb_count
    );
endinterface

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - retire stage: ALU/load result, timed memory read, register file commit
module writeback_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    writeback_stage_if.master  bus
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOAD_WAIT = 2'd1;
    localparam logic [1:0] WRITE     = 2'd2;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] rd_q, rd_d;
    logic [7:0] data_q, data_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wait_q, wait_d;
    logic       err_q, err_d;
    logic [7:0] count_q, count_d;

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        data_d  = data_q;
        addr_d  = addr_q;
        wait_d  = wait_q;
        err_d   = err_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    rd_d = bus.in_rd;
                    if (bus.in_is_load) begin
                        addr_d  = bus.in_mem_addr;
                        wait_d  = 8'd0;
                        state_d = LOAD_WAIT;
                    end else begin
                        data_d  = bus.in_alu_result;
                        state_d = WRITE;
                    end
                end
            end
            LOAD_WAIT: begin
                wait_d = wait_q + 8'd1;
                // A completion on the final wait cycle still counts as a hit.
                if (bus.mem_ready) begin
                    data_d  = bus.mem_rdata;
                    state_d = WRITE;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (bus.rf_ready) begin
                    state_d = IDLE;
                    if (rd_q != 3'd0) begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rd_q    <= 3'd0;
            data_q  <= 8'd0;
            addr_q  <= 8'd0;
            wait_q  <= 8'd0;
            err_q   <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    logic in_write, in_wait, write_live;
    assign in_write   = (state_q == WRITE);
    assign in_wait    = (state_q == LOAD_WAIT);
    assign write_live = in_write && (rd_q != 3'd0);

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.mem_req     = in_wait;
    assign bus.mem_addr    = in_wait ? addr_q : 8'd0;
    assign bus.rf_write_en = write_live && bus.rf_ready;
    assign bus.rf_addr_wr  = in_write ? rd_q : 3'd0;
    assign bus.rf_data_wr  = in_write ? data_q : 8'd0;
    assign bus.fwd_valid   = write_live;
    assign bus.fwd_rd      = write_live ? rd_q : 3'd0;
    assign bus.fwd_data    = write_live ? data_q : 8'd0;
    assign bus.err_timeout = err_q;
    assign bus.wb_count    = count_q;
endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - scoreboard bench for writeback_stage with random retire traffic
module tb_writeback_stage;
    localparam int TO = 4;

    typedef struct {
        logic [2:0] rd;
        logic [7:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    writeback_stage_if bus ();
    writeback_stage #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    wr_t        exp_q[$];
    int         len_q[$];
    logic [7:0] m_count = 8'd0;
    logic       m_err   = 1'b0;
    logic [7:0] cur_addr = 8'd0;

    int         mem_lat   = 1000;
    logic [7:0] mem_data  = 8'd0;
    int         mem_cnt   = 0;
    bit         resp_en   = 1'b1;
    bit         force_rdy = 1'b0;
    int         bp_mode   = 0;
    bit         rf_hold   = 1'b1;
    int         req_run   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: completes a read on the mem_lat-th request cycle.
    always @(posedge clk) begin
        #1;
        if (!resp_en) begin
            mem_cnt       = 0;
            bus.mem_ready = force_rdy;
            bus.mem_rdata = 8'hEE;
        end else if (bus.mem_req) begin
            mem_cnt++;
            bus.mem_ready = (mem_cnt == mem_lat);
            bus.mem_rdata = (mem_cnt == mem_lat) ? mem_data : 8'h00;
        end else begin
            mem_cnt       = 0;
            bus.mem_ready = 1'b0;
            bus.mem_rdata = 8'h00;
        end
    end

    always @(posedge clk) begin
        #1;
        if (bp_mode == 0)      bus.rf_ready = 1'b1;
        else if (bp_mode == 1) bus.rf_ready = ($urandom_range(0, 2) != 0);
        else                   bus.rf_ready = rf_hold;
    end

    // Monitor: pops the scoreboard on every register file write.
    always @(negedge clk) begin
        if (rst) begin
            req_run = 0;
        end else begin
            if (bus.rf_write_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {29'd0, bus.rf_addr_wr}, 32'hFFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", bus.rf_addr_wr, e.rd);
                    check("wr_data", bus.rf_data_wr, e.data);
                end
            end
            if (bus.fwd_valid) begin
                check("fwd_rd", bus.fwd_rd, bus.rf_addr_wr);
                check("fwd_data", bus.fwd_data, bus.rf_data_wr);
                check("wr_en_vs_ready", bus.rf_write_en, bus.rf_ready);
            end else begin
                check("fwd_idle_zero", {bus.rf_write_en, bus.fwd_rd, bus.fwd_data}, 0);
            end
            if (bus.mem_req) begin
                check("mem_addr", bus.mem_addr, cur_addr);
                req_run++;
            end else begin
                check("mem_addr_idle", bus.mem_addr, 0);
                if (req_run > 0 && len_q.size() > 0) check("req_len", req_run, len_q.pop_front());
                req_run = 0;
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!bus.in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.in_ready) check("ready_timeout", bus.in_ready, 1);
    endtask

    task automatic issue(input bit is_load, input logic [2:0] rd, input logic [7:0] val,
                         input logic [7:0] addr, input int lat);
        bit writes;
        wait_ready();
        writes = 1'b1;
        if (is_load) begin
            mem_lat  = lat;
            mem_data = val;
            cur_addr = addr;
            len_q.push_back(lat <= TO ? lat : TO);
            if (lat > TO) begin
                m_err  = 1'b1;
                writes = 1'b0;
            end
        end
        if (writes && rd != 3'd0) begin
            exp_q.push_back('{rd: rd, data: val});
            m_count = m_count + 8'd1;
        end
        bus.in_valid      = 1'b1;
        bus.in_is_load    = is_load;
        bus.in_rd         = rd;
        bus.in_alu_result = is_load ? 8'($urandom) : val;
        bus.in_mem_addr   = is_load ? addr : 8'($urandom);
        @(posedge clk); #1;
        bus.in_valid      = 1'b0;
        bus.in_rd         = 3'($urandom);
        bus.in_alu_result = 8'($urandom);
        bus.in_mem_addr   = 8'($urandom);
    endtask

    task automatic drain();
        wait_ready();
        @(negedge clk);
        check("wb_count", bus.wb_count, m_count);
        check("err_timeout", bus.err_timeout, m_err);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_count = 8'd0;
        m_err   = 1'b0;
        exp_q.delete();
        len_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_rd = 3'd0;
        bus.in_is_load = 1'b0;
        bus.in_alu_result = 8'd0;
        bus.in_mem_addr = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_outputs", {bus.mem_req, bus.mem_addr, bus.rf_write_en, bus.rf_addr_wr,
                              bus.rf_data_wr, bus.fwd_valid, bus.err_timeout}, 0);
        check("rst_wb_count", bus.wb_count, 0);

        issue(1'b0, 3'd3, 8'hA5, 8'h00, 0);
        @(negedge clk);
        check("alu_wr_en", bus.rf_write_en, 1);
        check("alu_fwd", {bus.fwd_valid, bus.fwd_rd, bus.fwd_data}, {1'b1, 3'd3, 8'hA5});
        check("alu_busy", bus.in_ready, 0);
        @(negedge clk);
        check("alu_ready_again", bus.in_ready, 1);
        check("alu_count", bus.wb_count, 1);
        drain();

        issue(1'b1, 3'd5, 8'h3C, 8'h40, 3);
        drain();

        issue(1'b1, 3'd6, 8'h77, 8'h80, 1000);
        drain();

        do_reset();
        issue(1'b1, 3'd4, 8'h99, 8'h22, TO);
        drain();

        bp_mode = 2;
        rf_hold = 1'b0;
        issue(1'b0, 3'd2, 8'h11, 8'h00, 0);
        bus.in_is_load = 1'b0;
        bus.in_rd = 3'd7;
        bus.in_alu_result = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            check("stall_in_ready", bus.in_ready, 0);
            check("stall_fwd", {bus.fwd_valid, bus.fwd_rd, bus.fwd_data}, {1'b1, 3'd2, 8'h11});
        end
        bus.in_valid = 1'b0;
        rf_hold = 1'b1;
        drain();
        bp_mode = 0;

        issue(1'b0, 3'd0, 8'h5A, 8'h00, 0);
        @(negedge clk);
        check("r0_no_fwd", {bus.rf_write_en, bus.fwd_valid}, 0);
        check("r0_busy", bus.in_ready, 0);
        @(negedge clk);
        check("r0_ready_again", bus.in_ready, 1);
        drain();

        do_reset();
        for (int i = 0; i < 256; i++) issue(1'b0, 3'd1, 8'(i), 8'h00, 0);
        drain();
        check("wrap_zero", bus.wb_count, 0);

        issue(1'b0, 3'd1, 8'h01, 8'h00, 0);
        drain();
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_is_load = 1'b1;
        bus.in_rd = 3'd5;
        bus.in_mem_addr = 8'hF0;
        cur_addr = 8'hF0;
        mem_lat = 1000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        check("rstload_mem_req", bus.mem_req, 0);
        check("rstload_in_ready", bus.in_ready, 1);
        check("rstload_err", bus.err_timeout, 0);
        check("rstload_count", bus.wb_count, 0);
        resp_en = 1'b0;
        force_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check("late_ready_ignored", {bus.mem_req, bus.rf_write_en, bus.fwd_valid}, 0);
        force_rdy = 1'b0;
        @(posedge clk); #1;
        resp_en = 1'b1;

        bp_mode = 1;
        for (int i = 0; i < 80; i++) begin
            issue(1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), $urandom_range(1, TO + 2));
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
